// File: rtl/reg_readback_sel_if.sv
// Read request/response bundle between the SPI address/strobe logic and
// the read-back selector.
interface reg_readback_sel_if #(
  parameter int ADDR_W = 8
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_err;

  modport master (
    output rd_req, addr,
    input  rd_data, rd_valid, rd_err
  );

  modport slave (
    input  rd_req, addr,
    output rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/reg_readback_sel.sv
// Registered byte read-back selector: version, err_cnt, MOSI echo, counters.
// Define SEL_SNAPSHOT_EN for coherent multi-byte counter reads via shadows.
module reg_readback_sel #(
  parameter int          ADDR_W   = 8,
  parameter int          N_CH     = 4,
  parameter int          CH_BYTES = 4,
  parameter int          BASE_CNT = 'h26,
  parameter logic [7:0]  VERSION  = 8'h01
) (
  input  logic                        clk,
  input  logic                        rst_n,
  reg_readback_sel_if.slave           bus,
  input  logic [7:0]                  mosi,
  input  logic [N_CH*CH_BYTES*8-1:0]  cnt
);

  localparam int CH_W    = CH_BYTES * 8;
  localparam int CNT_END = BASE_CNT + N_CH * CH_BYTES;

  // Reject maps where counters collide with the fixed registers or run off
  // the end of the address space.
  if (BASE_CNT < 3 || CNT_END > (2 ** ADDR_W) || CH_BYTES < 1 || CH_BYTES > 8
      || N_CH < 1) begin : g_bad_map
    $error("reg_readback_sel: invalid counter address map");
  end

  logic [7:0] err_cnt;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;
  logic       rd_err_q;

  logic       mapped;
  logic       is_err_addr;
  logic [7:0] sel_data;

`ifdef SEL_SNAPSHOT_EN
  logic [CH_W-1:0] shadow [N_CH];
  logic [N_CH-1:0] load_ch;
`endif

  // NOTE: every comb output gets a default first so no path leaves a latch;
  // blocking '=' is correct here because this block models wires, not state.
  always_comb begin
    mapped      = 1'b0;
    is_err_addr = 1'b0;
    sel_data    = 8'h00;
`ifdef SEL_SNAPSHOT_EN
    load_ch     = '0;
`endif
    if (bus.addr == ADDR_W'(0)) begin
      mapped   = 1'b1;
      sel_data = VERSION;
    end else if (bus.addr == ADDR_W'(1)) begin
      mapped      = 1'b1;
      is_err_addr = 1'b1;
      sel_data    = err_cnt;
    end else if (bus.addr == ADDR_W'(2)) begin
      mapped   = 1'b1;
      sel_data = mosi;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        for (int b = 0; b < CH_BYTES; b++) begin
          if (32'(bus.addr) == 32'(BASE_CNT + k * CH_BYTES + b)) begin
            mapped = 1'b1;
`ifdef SEL_SNAPSHOT_EN
            // Byte 0 is always live and arms the snapshot for bytes 1..N.
            if (b == 0) begin
              sel_data   = cnt[k*CH_W +: 8];
              load_ch[k] = 1'b1;
            end else begin
              sel_data = shadow[k][b*8 +: 8];
            end
`else
            sel_data = cnt[(k*CH_BYTES + b)*8 +: 8];
`endif
          end
        end
      end
    end
  end

  // NOTE: state uses non-blocking '<=' so every register samples pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      err_cnt    <= 8'h00;
    end else begin
      rd_valid_q <= bus.rd_req;
      rd_err_q   <= bus.rd_req && !mapped;
      if (bus.rd_req) begin
        rd_data_q <= sel_data;
        if (is_err_addr) begin
          err_cnt <= 8'h00;
        end else if (!mapped && err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'h01;
        end
      end
    end
  end

`ifdef SEL_SNAPSHOT_EN
  // NOTE: the shadow array is reset explicitly because a byte>0 read before
  // any byte-0 read must return a defined 0, not power-up garbage.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (!rst_n) begin
        shadow[k] <= '0;
      end else if (bus.rd_req && load_ch[k]) begin
        shadow[k] <= cnt[k*CH_W +: CH_W];
      end
    end
  end
`endif

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;

endmodule

// File: tb/tb_reg_readback_sel.sv
// Directed bench for reg_readback_sel; expectations follow SEL_SNAPSHOT_EN
// when the bench is built with the same macro as the design.
module tb_reg_readback_sel;

  localparam int ADDR_W   = 8;
  localparam int N_CH     = 4;
  localparam int CH_BYTES = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [7:0]                 mosi;
  logic [N_CH*CH_BYTES*8-1:0] cnt;

  int passed = 0;
  int total  = 0;

  reg_readback_sel_if #(.ADDR_W(ADDR_W)) bus ();

  reg_readback_sel #(
    .ADDR_W   (ADDR_W),
    .N_CH     (N_CH),
    .CH_BYTES (CH_BYTES),
    .BASE_CNT ('h26),
    .VERSION  (8'h01)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .mosi  (mosi),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  // Single read: request on one edge, sample the response half a cycle later.
  task automatic do_read(input logic [7:0] a, output logic [7:0] d,
                         output logic v, output logic e);
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.addr   = a;
    @(negedge clk);
    bus.rd_req = 1'b0;
    d = bus.rd_data;
    v = bus.rd_valid;
    e = bus.rd_err;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       v, e;
    rst_n      = 1'b0;
    bus.rd_req = 1'b1;
    bus.addr   = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.rd_err !== 1'b0)
      $display("FAIL reset_outputs: got valid=%b data=%h err=%b want 0/00/0",
               bus.rd_valid, bus.rd_data, bus.rd_err);
    else passed++;
    rst_n      = 1'b1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rd_valid !== 1'b0)
      $display("FAIL reset_req_dropped: got valid=%b want 0", bus.rd_valid);
    else passed++;
    do_read(8'h00, d, v, e);
    total++;
    if (v !== 1'b1 || d !== 8'h01 || e !== 1'b0)
      $display("FAIL version: got valid=%b data=%h err=%b want 1/01/0", v, d, e);
    else passed++;
  endtask

  task automatic test_mosi();
    logic [7:0] d;
    logic       v, e;
    mosi = 8'hA5;
    do_read(8'h02, d, v, e);
    total++;
    if (v !== 1'b1 || d !== 8'hA5 || e !== 1'b0)
      $display("FAIL mosi_echo: got valid=%b data=%h err=%b want 1/a5/0", v, d, e);
    else passed++;
    mosi = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hA5)
        $display("FAIL mosi_hold%0d: got valid=%b data=%h want 0/a5",
                 i, bus.rd_valid, bus.rd_data);
      else passed++;
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] d;
    logic       v, e;
    logic [7:0] exp_hi [3];
`ifdef SEL_SNAPSHOT_EN
    exp_hi = '{8'h33, 8'h22, 8'h11};
`else
    exp_hi = '{8'hFF, 8'hFF, 8'hFF};
`endif
    cnt[32 +: 32] = 32'h11223344;
    do_read(8'h2A, d, v, e);
    total++;
    if (d !== 8'h44 || v !== 1'b1)
      $display("FAIL snap_byte0: got data=%h valid=%b want 44/1", d, v);
    else passed++;
    cnt[32 +: 32] = 32'hFFFFFFFF;
    for (int b = 1; b < 4; b++) begin
      do_read(8'h2A + 8'(b), d, v, e);
      total++;
      if (d !== exp_hi[b-1] || e !== 1'b0)
        $display("FAIL snap_byte%0d: got data=%h err=%b want %h/0",
                 b, d, e, exp_hi[b-1]);
      else passed++;
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    logic       v, e;
    for (int i = 0; i < 3; i++) begin
      do_read(8'h03, d, v, e);
      total++;
      if (v !== 1'b1 || e !== 1'b1 || d !== 8'h00)
        $display("FAIL unmapped%0d: got valid=%b err=%b data=%h want 1/1/00",
                 i, v, e, d);
      else passed++;
    end
    do_read(8'h01, d, v, e);
    total++;
    if (d !== 8'h03 || e !== 1'b0)
      $display("FAIL err_cnt_3: got data=%h err=%b want 03/0", d, e);
    else passed++;
    do_read(8'h01, d, v, e);
    total++;
    if (d !== 8'h00)
      $display("FAIL err_cnt_clear: got %h want 00", d);
    else passed++;
    for (int i = 0; i < 300; i++) do_read((i % 2 == 0) ? 8'h36 : 8'hFF, d, v, e);
    total++;
    if (e !== 1'b1 || d !== 8'h00)
      $display("FAIL unmapped_top: got err=%b data=%h want 1/00", e, d);
    else passed++;
    do_read(8'h01, d, v, e);
    total++;
    if (d !== 8'hFF)
      $display("FAIL err_cnt_sat: got %h want ff", d);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [4];
    exp_d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    cnt[0 +: 32] = 32'hDEADBEEF;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d[i-1])
          $display("FAIL b2b_%0d: got valid=%b data=%h want 1/%h",
                   i - 1, bus.rd_valid, bus.rd_data, exp_d[i-1]);
        else passed++;
      end
      if (i < 4) begin
        bus.rd_req = 1'b1;
        bus.addr   = 8'h26 + 8'(i);
      end else begin
        bus.rd_req = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (bus.rd_valid !== 1'b0)
      $display("FAIL b2b_end: got valid=%b want 0", bus.rd_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       v, e;
    logic [7:0] exp_after;
`ifdef SEL_SNAPSHOT_EN
    exp_after = 8'h00;
`else
    exp_after = 8'h33;
`endif
    cnt[32 +: 32] = 32'h11223344;
    do_read(8'h2A, d, v, e);
    total++;
    if (d !== 8'h44)
      $display("FAIL mid_load: got %h want 44", d);
    else passed++;
    @(negedge clk);
    rst_n      = 1'b0;
    bus.rd_req = 1'b1;
    bus.addr   = 8'h2B;
    @(negedge clk);
    rst_n      = 1'b1;
    bus.rd_req = 1'b0;
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00)
      $display("FAIL mid_reset: got valid=%b data=%h want 0/00",
               bus.rd_valid, bus.rd_data);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.rd_valid !== 1'b0)
      $display("FAIL mid_req_dropped: got valid=%b want 0", bus.rd_valid);
    else passed++;
    do_read(8'h2B, d, v, e);
    total++;
    if (d !== exp_after || v !== 1'b1)
      $display("FAIL mid_after: got data=%h valid=%b want %h/1", d, v, exp_after);
    else passed++;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.rd_req = 1'b0;
    bus.addr   = '0;
    mosi       = 8'h00;
    cnt        = '0;
    test_reset();
    test_mosi();
    test_snapshot();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_readback_sel.md
Name: reg_readback_sel

Overview:
- Registered, parametrised read-back selector for the SPI register space.
- Returns one byte per read request from version, status, MOSI echo and N_CH multi-byte counter channels.
- Optional shadow snapshot keeps multi-byte counter reads coherent.
- Tracks unmapped-address reads in a read-to-clear error counter.
- Sits between the SPI slave address/strobe logic and the MISO shift register.

Parameters:
- ADDR_W, 8, address width.
- N_CH, 4, number of counter channels.
- CH_BYTES, 4, bytes per counter channel; range 1..8.
- BASE_CNT, 8'h26, address of channel 0 byte 0.
- VERSION, 8'h01, value returned at address 0x00.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- rd_req  input  1  one-cycle read strobe.
- addr  input  ADDR_W  read address, valid when rd_req=1.
- mosi  input  8  last byte received from the SPI master.
- cnt  input  N_CH*CH_BYTES*8  live counter values, packed flat.
  - Channel k occupies bits [(k+1)*CH_BYTES*8-1 : k*CH_BYTES*8].
- rd_data  output  8  selected byte.
- rd_valid  output  1  one-cycle pulse; rd_data is valid in this cycle.
- rd_err  output  1  one-cycle pulse together with rd_valid when the address is unmapped.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - rd_data=0, rd_valid=0, rd_err=0, err_cnt=0, all shadow registers=0.
  - A rd_req in the reset cycle is dropped; no rd_valid follows.
- Latency: rd_req at edge T gives rd_valid=1 and rd_data for the cycle after T. One result per cycle; back-to-back requests are allowed.
- rd_data holds its last value when rd_req=0. rd_valid and rd_err are 0 when rd_req=0.
- Address map:
  - 0x00: VERSION.
  - 0x01: err_cnt.
  - 0x02: mosi, sampled at the request edge.
  - BASE_CNT + k*CH_BYTES + b: byte b of channel k, little-endian (b=0 is bits [7:0]), for k < N_CH and b < CH_BYTES.
  - Any other address is unmapped: rd_data=0, rd_err=1.
- Map constraint: the counter region must not overlap 0x00..0x02 and must fit within 2^ADDR_W. Violating this is a compile-time error, raised by a generate-time check.
- err_cnt (8 bit):
  - Increments on each unmapped read and saturates at 0xFF.
  - A read of 0x01 returns the current value, then clears it to 0 in the same edge.
  - An unmapped read and a 0x01 read cannot coincide, since there is one address per cycle.
- Address decode is combinational from addr. Output registers update only when rd_req=1.
- Shadow per channel: a CH_BYTES*8 register (see Optional Feature).

Optional Feature:
- Macro: SEL_SNAPSHOT_EN.
- Defined:
  - A read of byte 0 of channel k returns the live cnt byte 0 and, in the same edge, loads the shadow of channel k with the full live channel value.
  - Reads of bytes 1..CH_BYTES-1 of channel k return the shadow, even if cnt has changed.
  - Reading byte b>0 with no prior byte-0 read since reset returns the shadow reset value, 0.
  - Shadows of other channels are unaffected.
- Undefined:
  - Shadow registers are not instantiated.
  - Every counter byte read returns the live cnt byte at the request edge.

Test Plan:
- Reset release, rd_req with addr=0x00 -> next cycle rd_valid=1, rd_data=0x01, rd_err=0.
- mosi=0xA5, rd_req addr=0x02 -> rd_data=0xA5. Then rd_req=0 for 3 cycles -> rd_data stays 0xA5, rd_valid=0.
- Snapshot (with SEL_SNAPSHOT_EN):
  - Channel 1 = 0x11223344, read 0x2A -> 0x44.
  - Change channel 1 to 0xFFFFFFFF, read 0x2B, 0x2C, 0x2D -> 0x33, 0x22, 0x11.
  - Without the macro, the same sequence -> 0xFF, 0xFF, 0xFF.
- Unmapped reads:
  - Read 0x03 three times -> each has rd_err=1, rd_data=0x00.
  - Read 0x01 -> 0x03. Read 0x01 again -> 0x00.
  - 300 unmapped reads followed by a read of 0x01 -> 0xFF.
- Back-to-back reads 0x26, 0x27, 0x28, 0x29 on consecutive cycles (channel 0 = 0xDEADBEEF) -> rd_valid high for 4 consecutive cycles, data 0xEF, 0xBE, 0xAD, 0xDE.
- Reset mid-operation:
  - Read 0x2A to load the snapshot, then assert rst_n=0 for one edge together with rd_req addr=0x2B -> no rd_valid follows, rd_data=0.
  - Read 0x2B after reset -> 0x00 with SEL_SNAPSHOT_EN; the live byte without it.
